// File: rtl/change_sequencer_if.sv
// Bus bundle for the change sequencer: payout request, refill strobe,
// hopper drives and inventory/status readback.
interface change_sequencer_if;
    logic       start;
    logic [7:0] amount;
    logic       refill;
    logic [1:0] refill_sel;
    logic [7:0] refill_qty;
    logic       busy;
    logic       done;
    logic       eject_5;
    logic       eject_10;
    logic       eject_25;
    logic [7:0] cnt_5;
    logic [7:0] cnt_10;
    logic [7:0] cnt_25;
    logic [7:0] shortfall;
    logic       short_err;

    modport master (
        output start, amount, refill, refill_sel, refill_qty,
        input  busy, done, eject_5, eject_10, eject_25,
        input  cnt_5, cnt_10, cnt_25, shortfall, short_err
    );

    modport slave (
        input  start, amount, refill, refill_sel, refill_qty,
        output busy, done, eject_5, eject_10, eject_25,
        output cnt_5, cnt_10, cnt_25, shortfall, short_err
    );
endinterface

// File: rtl/change_sequencer.sv
// Greedy coin-change payout sequencer: pulses one hopper at a time (25c, 10c, 5c
// priority) and reports any unpayable remainder as a shortfall.
module change_sequencer #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 8,
    parameter int unsigned INIT_N5      = 20,
    parameter int unsigned INIT_N10     = 20,
    parameter int unsigned INIT_N25     = 20
) (
    input logic                clk,
    input logic                reset,
    change_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;
    typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_10, COIN_25} coin_t;

    // Timers count down to zero, so they load one less than the duration.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_t     state;
    coin_t      pick;
    logic [7:0] remaining;
    logic [7:0] timer;
    logic [7:0] cnt_5, cnt_10, cnt_25;
    logic [7:0] shortfall;
    logic       short_err;
    logic       busy, done;
    logic       eject_5, eject_10, eject_25;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns pick and no latch is inferred.
        pick = COIN_NONE;
        if (remaining >= 8'd25 && cnt_25 != 8'd0)
            pick = COIN_25;
        else if (remaining >= 8'd10 && cnt_10 != 8'd0)
            pick = COIN_10;
        else if (remaining >= 8'd5 && cnt_5 != 8'd0)
            pick = COIN_5;
    end

    // NOTE: all state here uses non-blocking assignments so every register sees
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= 8'd0;
            timer     <= 8'd0;
            cnt_5     <= 8'(INIT_N5);
            cnt_10    <= 8'(INIT_N10);
            cnt_25    <= 8'(INIT_N25);
            shortfall <= 8'd0;
            short_err <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eject_5   <= 1'b0;
            eject_10  <= 1'b0;
            eject_25  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.refill) begin
                        unique case (bus.refill_sel)
                            2'b00:   cnt_5  <= sat_add(cnt_5,  bus.refill_qty);
                            2'b01:   cnt_10 <= sat_add(cnt_10, bus.refill_qty);
                            2'b10:   cnt_25 <= sat_add(cnt_25, bus.refill_qty);
                            default: ;
                        endcase
                    end
                    if (bus.start) begin
                        remaining <= bus.amount;
                        shortfall <= 8'd0;
                        short_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    unique case (pick)
                        COIN_25: begin
                            cnt_25    <= cnt_25 - 8'd1;
                            remaining <= remaining - 8'd25;
                            eject_25  <= 1'b1;
                        end
                        COIN_10: begin
                            cnt_10    <= cnt_10 - 8'd1;
                            remaining <= remaining - 8'd10;
                            eject_10  <= 1'b1;
                        end
                        COIN_5: begin
                            cnt_5     <= cnt_5 - 8'd1;
                            remaining <= remaining - 8'd5;
                            eject_5   <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (pick == COIN_NONE) begin
                        shortfall <= remaining;
                        short_err <= (remaining != 8'd0);
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= PULSE_LOAD;
                        state <= EJECT;
                    end
                end
                EJECT: begin
                    if (timer == 8'd0) begin
                        eject_5  <= 1'b0;
                        eject_10 <= 1'b0;
                        eject_25 <= 1'b0;
                        timer    <= GAP_LOAD;
                        state    <= GAP;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                GAP: begin
                    if (timer == 8'd0)
                        state <= SELECT;
                    else
                        timer <= timer - 8'd1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.eject_5   = eject_5;
    assign bus.eject_10  = eject_10;
    assign bus.eject_25  = eject_25;
    assign bus.cnt_5     = cnt_5;
    assign bus.cnt_10    = cnt_10;
    assign bus.cnt_25    = cnt_25;
    assign bus.shortfall = shortfall;
    assign bus.short_err = short_err;
endmodule

// File: tb/tb_change_sequencer.sv
// Self-checking bench for change_sequencer: vector table, directed corner cases
// and randomized transactions against a greedy-payout reference model.
`timescale 1ns/1ps
module tb_change_sequencer;
    localparam int P    = 4;
    localparam int G    = 8;
    localparam int SLOT = 1 + P + G;   // clocks consumed per ejected coin

    logic clk = 1'b0;
    logic reset;

    change_sequencer_if bus ();

    change_sequencer #(
        .PULSE_CYCLES(P), .GAP_CYCLES(G),
        .INIT_N5(20), .INIT_N10(20), .INIT_N25(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m5, m10, m25;   // reference inventory

    typedef struct {
        int amount;
        int d25, d10, d5;   // coins of each kind used, from a fresh inventory
        int short_exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_refill(input int sel, input int qty);
        case (sel)
            0: m5  = sat(m5 + qty);
            1: m10 = sat(m10 + qty);
            2: m25 = sat(m25 + qty);
            default: ;
        endcase
    endtask

    task automatic apply_reset();
        bus.start = 1'b0; bus.refill = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m5 = 20; m10 = 20; m25 = 20;
        @(negedge clk);
    endtask

    task automatic do_refill(input int sel, input int qty);
        bus.refill = 1'b1; bus.refill_sel = 2'(sel); bus.refill_qty = 8'(qty);
        model_refill(sel, qty);
        @(negedge clk);
        bus.refill = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, " cnt_5"},  bus.cnt_5,  m5);
        check({tag, " cnt_10"}, bus.cnt_10, m10);
        check({tag, " cnt_25"}, bus.cnt_25, m25);
    endtask

    // One payout starting at cycle 0 (called at a negedge, DUT idle). The model
    // pays greedily, then every cycle is compared against the resulting timeline.
    // rsel < 0 means no refill alongside start.
    task automatic run_txn(input int amt, input bit noise, input int rsel, input int rqty);
        int coins[$];
        int rem, done_cyc, exp_coin;
        if (rsel >= 0) model_refill(rsel, rqty);
        rem = amt;
        forever begin
            if (rem >= 25 && m25 > 0)      begin coins.push_back(25); m25--; rem -= 25; end
            else if (rem >= 10 && m10 > 0) begin coins.push_back(10); m10--; rem -= 10; end
            else if (rem >= 5 && m5 > 0)   begin coins.push_back(5);  m5--;  rem -= 5;  end
            else break;
        end
        done_cyc = 2 + SLOT * coins.size();

        bus.start = 1'b1; bus.amount = 8'(amt);
        bus.refill = (rsel >= 0);
        bus.refill_sel = 2'(rsel); bus.refill_qty = 8'(rqty);
        @(negedge clk);
        bus.start = 1'b0; bus.refill = 1'b0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            exp_coin = 0;
            if (c >= 2 && c < done_cyc && (c - 2) % SLOT < P)
                exp_coin = coins[(c - 2) / SLOT];
            check($sformatf("busy c%0d", c), bus.busy, c <= done_cyc);
            check($sformatf("done c%0d", c), bus.done, c == done_cyc);
            check($sformatf("eject_25 c%0d", c), bus.eject_25, exp_coin == 25);
            check($sformatf("eject_10 c%0d", c), bus.eject_10, exp_coin == 10);
            check($sformatf("eject_5 c%0d", c),  bus.eject_5,  exp_coin == 5);
            if (c == 1) begin
                check("shortfall cleared", bus.shortfall, 0);
                check("short_err cleared", bus.short_err, 0);
            end
            // Busy-time start/refill must be ignored; the model leaves them out.
            if (noise && c <= done_cyc) begin
                bus.start      = 1'($urandom_range(0, 1));
                bus.amount     = 8'($urandom);
                bus.refill     = 1'($urandom_range(0, 1));
                bus.refill_sel = 2'($urandom);
                bus.refill_qty = 8'($urandom);
            end else begin
                bus.start = 1'b0; bus.refill = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("shortfall amt=%0d", amt), bus.shortfall, rem);
        check($sformatf("short_err amt=%0d", amt), bus.short_err, rem != 0);
        check_counts($sformatf("after amt=%0d", amt));
    endtask

    initial begin
        vec_t vecs[9];
        vecs = '{
            '{30,  1, 0, 1, 0},
            '{0,   0, 0, 0, 0},
            '{37,  1, 1, 0, 2},
            '{4,   0, 0, 0, 4},
            '{255, 10, 0, 1, 0},
            '{99,  3, 2, 0, 4},
            '{41,  1, 1, 1, 1},
            '{60,  2, 1, 0, 0},
            '{15,  0, 1, 1, 0}
        };
        bus.start = 1'b0; bus.amount = 8'd0;
        bus.refill = 1'b0; bus.refill_sel = 2'd0; bus.refill_qty = 8'd0;
        reset = 1'b1;
        #12;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset ejects", {bus.eject_25, bus.eject_10, bus.eject_5}, 0);
        check("reset shortfall", bus.shortfall, 0);
        check("reset short_err", bus.short_err, 0);
        check("reset cnt_5", bus.cnt_5, 20);
        check("reset cnt_10", bus.cnt_10, 20);
        check("reset cnt_25", bus.cnt_25, 20);

        // Vector table, each from a fresh inventory.
        foreach (vecs[i]) begin
            apply_reset();
            run_txn(vecs[i].amount, 1'b0, -1, 0);
            check($sformatf("vec%0d used25", i), 20 - int'(bus.cnt_25), vecs[i].d25);
            check($sformatf("vec%0d used10", i), 20 - int'(bus.cnt_10), vecs[i].d10);
            check($sformatf("vec%0d used5", i),  20 - int'(bus.cnt_5),  vecs[i].d5);
            check($sformatf("vec%0d shortfall", i), bus.shortfall, vecs[i].short_exp);
            check($sformatf("vec%0d short_err", i), bus.short_err, vecs[i].short_exp != 0);
        end

        // Exhaust 25c coins, then 25 cents must come out as 10, 10, 5.
        apply_reset();
        run_txn(255, 1'b0, -1, 0);
        run_txn(255, 1'b0, -1, 0);
        check("cnt_25 exhausted", bus.cnt_25, 0);
        run_txn(25, 1'b0, -1, 0);
        check("no-25 cnt_10", bus.cnt_10, 18);
        check("no-25 cnt_5", bus.cnt_5, 17);
        // Refill with start in the same cycle: SELECT must see the new 25c coin.
        run_txn(25, 1'b0, 2, 1);
        check("refill+start cnt_25", bus.cnt_25, 0);
        check("refill+start cnt_10", bus.cnt_10, 18);

        // Saturating refill, ignored selector 11, ignored busy refill.
        apply_reset();
        do_refill(2, 250);
        check("refill sat cnt_25", bus.cnt_25, 255);
        do_refill(3, 9);
        check_counts("refill sel11");
        run_txn(25, 1'b1, -1, 0);
        check("busy refill cnt_25", bus.cnt_25, 254);
        check("busy refill cnt_5", bus.cnt_5, 20);
        check("busy refill cnt_10", bus.cnt_10, 20);

        // Asynchronous reset during the third cycle of an eject pulse.
        apply_reset();
        bus.start = 1'b1; bus.amount = 8'd30;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);   // now in cycle 4
        check("pre-reset eject_25", bus.eject_25, 1);
        check("pre-reset cnt_25", bus.cnt_25, 19);
        #1 reset = 1'b1;
        #1;
        check("async reset eject_25", bus.eject_25, 0);
        check("async reset busy", bus.busy, 0);
        check("async reset cnt_25", bus.cnt_25, 20);
        @(negedge clk);
        reset = 1'b0;
        m5 = 20; m10 = 20; m25 = 20;
        @(negedge clk);
        run_txn(30, 1'b0, -1, 0);

        // Randomized traffic with idle refills, busy-time noise and saturation.
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0)
                do_refill($urandom_range(0, 3), $urandom_range(0, 255));
            run_txn($urandom_range(0, 255), 1'b1,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
                    $urandom_range(0, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/change_sequencer.md
CHANGE_SEQUENCER -- requirements
Module: change_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PULSE_CYCLES, 4, eject pulse width in clocks (legal 1..255).
- GAP_CYCLES, 8, idle clocks after each eject pulse (legal 1..255).
- INIT_N5, 20, reset inventory of 5-cent coins.
- INIT_N10, 20, reset inventory of 10-cent coins.
- INIT_N25, 20, reset inventory of 25-cent coins.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, request to pay out change; sampled only in IDLE.
- amount, in, 8, change to pay, in cents; latched on accepted start.
- refill, in, 1, single-cycle inventory refill strobe.
- refill_sel, in, 2, refill target: 00 = 5c, 01 = 10c, 10 = 25c, 11 = ignored.
- refill_qty, in, 8, number of coins to add.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle completion pulse.
- eject_5, out, 1, hopper drive for the 5c coin.
- eject_10, out, 1, hopper drive for the 10c coin.
- eject_25, out, 1, hopper drive for the 25c coin.
- cnt_5, out, 8, current 5c inventory.
- cnt_10, out, 8, current 10c inventory.
- cnt_25, out, 8, current 25c inventory.
- shortfall, out, 8, cents left unpaid by the last transaction.
- short_err, out, 1, high when shortfall is not zero.

Function
REQ-003 The FSM SHALL have five states: IDLE, SELECT, EJECT, GAP and DONE; all transitions occur on the rising edge of clk.
REQ-004 IDLE -> SELECT on start = 1:
- remaining <= amount.
- shortfall <= 0 and short_err <= 0 on the same edge.
REQ-005 start SHALL be ignored in every state except IDLE; a mid-transaction start has no effect.
REQ-006 SELECT SHALL choose a coin greedily, checked in this order:
- 25c if remaining >= 25 and cnt_25 > 0;
- otherwise 10c if remaining >= 10 and cnt_10 > 0;
- otherwise 5c if remaining >= 5 and cnt_5 > 0;
- otherwise no coin, and the FSM goes to DONE.
REQ-007 On SELECT -> EJECT:
- the chosen count decrements by 1;
- remaining decreases by the coin value;
- both updates occur on that edge.
REQ-008 EJECT SHALL hold exactly one eject line high for exactly PULSE_CYCLES clocks, then go to GAP.
REQ-009 GAP SHALL hold all eject lines low for exactly GAP_CYCLES clocks, then go to SELECT.
REQ-010 At most one eject line SHALL be high in any cycle; eject lines are high only in EJECT.
REQ-011 On SELECT -> DONE, shortfall <= remaining and short_err <= (remaining != 0).
- This covers non-multiples of 5 (remainder 1..4) and empty inventory.
- Both outputs hold until the next accepted start.
REQ-012 DONE SHALL last one cycle with done = 1, then return to IDLE.
REQ-013 amount = 0 SHALL give IDLE -> SELECT -> DONE with no eject and shortfall = 0.
REQ-014 refill SHALL apply only in IDLE:
- the selected count <= min(count + refill_qty, 255);
- refill_sel = 11 and refill while busy are ignored.
REQ-015 refill and start in the same IDLE cycle SHALL both take effect; SELECT uses the refilled count.
REQ-016 Arithmetic SHALL be 8-bit unsigned; counts never wrap below 0 or above 255.
REQ-017 Timers SHALL be 8 bits wide and reload on every entry to EJECT or GAP.

Reset
REQ-018 Reset SHALL act asynchronously, at any time including mid-EJECT, with these values:
- state = IDLE;
- busy, done, all eject lines and short_err = 0;
- shortfall = 0 and remaining = 0;
- cnt_5 = INIT_N5, cnt_10 = INIT_N10, cnt_25 = INIT_N25.
REQ-019 A transaction interrupted by reset SHALL NOT resume; decrements already applied are discarded by the count reload.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults, start at cycle 0):
- amount = 30 -> eject_25 high cycles 2-5, eject_5 high cycles 15-18, done at cycle 28; cnt_25 = 19, cnt_5 = 19, shortfall = 0.
- amount = 0 -> done at cycle 2, no eject, busy high cycles 1-2.
- amount = 37 -> coins 25, 10; shortfall = 2 and short_err = 1.
- cnt_25 = 0 and amount = 25 -> 10, 10, 5 ejected; cnt_10 = 18, cnt_5 = 19.
- refill_sel = 10 with qty 250 on INIT_N25 = 20 -> cnt_25 = 255; the same refill while busy -> no change.
- reset asserted in cycle 3 of an eject -> eject and busy go low immediately; counts return to INIT values; a later start runs normally.
